// File: rtl/demux1x2_stream_pkg.sv
// Shared definitions for the 1:2 stream demux: parameter legality and pointer sizing.
// Latency: n/a (elaboration-time helpers only).
// Backpressure: n/a.
package demux1x2_stream_pkg;

  // Smallest n with 2**n >= v; used to size FIFO pointers.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // FIFO depth must be a power of two so pointers wrap by plain overflow.
  function automatic bit depth_ok(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy counter; read data forced to 0 when empty.
// Latency: a word pushed at edge N is on rd_data just after edge N (fall-through view of head).
// Backpressure: push is ignored while full (even if popped that cycle); pop ignored while empty.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   push, wr_data     write request and word
//   pop               read request (advances head)
//   full, empty       occupancy flags
//   rd_data           head word, 0 when empty
module stream_fifo
  import demux1x2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = clog2_f(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             push_acc;
  logic             pop_acc;

  assign full     = (occ == FULL_OCC);
  assign empty    = (occ == '0);
  assign push_acc = push && !full;
  assign pop_acc  = pop && !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // Storage is not reset: empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= FULL_OCC);

endmodule

// File: rtl/demux1x2_stream.sv
// Routes one valid/ready stream to y0 or y1 per word (in_sel), each output buffered by its own FIFO.
// Latency: word accepted at edge N is valid on its output just after edge N; poppable at N+1.
// Backpressure: in_ready = !full of the selected FIFO only; a stalled output never blocks the other.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_sel input stream and per-word destination (0 -> y0, 1 -> y1)
//   y0_valid/y0_ready/y0_data        output stream 0
//   y1_valid/y1_ready/y1_data        output stream 1
//   cnt0, cnt1                       saturating pop counters for y0 / y1
module demux1x2_stream
  import demux1x2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("demux1x2_stream: DEPTH must be a power of two and at least 2");
  end

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic in_acc;

  // Ready depends only on the selected FIFO's fill level; no path from y*_ready,
  // so a full FIFO refuses a push even in a cycle where it is being drained.
  assign in_ready = in_sel ? !full1 : !full0;
  assign in_acc   = in_valid && in_ready;
  assign push0    = in_acc && !in_sel;
  assign push1    = in_acc && in_sel;

  assign y0_valid = !empty0;
  assign y1_valid = !empty1;
  assign pop0     = y0_valid && y0_ready;
  assign pop1     = y1_valid && y1_ready;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push0),
    .wr_data (in_data),
    .pop     (pop0),
    .full    (full0),
    .empty   (empty0),
    .rd_data (y0_data)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push1),
    .wr_data (in_data),
    .pop     (pop1),
    .full    (full1),
    .empty   (empty1),
    .rd_data (y1_data)
  );

  // Debug counters: count pops, stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0 && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
      if (pop1 && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
    end
  end

  // Producer contract: a refused word keeps its destination and data until taken or withdrawn.
  a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(in_sel) && $stable(in_data))));

endmodule

// File: doc/demux1x2_stream.md
Name: demux1x2_stream

Overview:
- Routes one valid/ready input stream to one of two output streams, selected per word by in_sel. It is the distributing counterpart to the 2:1 select logic used elsewhere in the design.
- Each output has its own small FIFO, so a stalled consumer only blocks words aimed at it.
- Per-output transfer counters support bring-up and debug.

Parameters:
- WIDTH, 8: data width of input and both outputs.
- DEPTH, 2: entries per output FIFO. Must be a power of two, at least 2.
- CNTW, 8: width of each saturating transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid is also high.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 selects output y0, 1 selects output y1.
- y0_valid  output  1  y0 head word present.
- y0_ready  input  1  y0 consumer accepts.
- y0_data  output  WIDTH  y0 head word.
- y1_valid  output  1  y1 head word present.
- y1_ready  input  1  y1 consumer accepts.
- y1_data  output  WIDTH  y1 head word.
- cnt0  output  CNTW  words popped from y0, saturating.
- cnt1  output  CNTW  words popped from y1, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both FIFOs are emptied: read/write pointers and occupancy go to 0.
  - y0_valid=0, y1_valid=0, y0_data=0, y1_data=0, cnt0=0, cnt1=0.
  - in_ready follows from the empty state, so it reads 1 during reset. No transfer is taken while rst_n=0.
- Reset asserted mid-operation discards all buffered words immediately. Outputs drop in the same instant, without waiting for a clock edge.
- in_ready = not full(FIFO[in_sel]):
  - It is combinational from in_sel and occupancy only.
  - It has no path from y*_ready. A full FIFO refuses a push even in a cycle where it is being popped.
- Input rule: in_sel and in_data are held stable while in_valid=1 and in_ready=0.
- Push: on a rising edge with in_valid and in_ready both 1, in_data is written at the write pointer of FIFO[in_sel]. The other FIFO is untouched.
- Pop: on a rising edge with yk_valid and yk_ready both 1, FIFO k's read pointer advances.
- yk_valid = occupancy_k != 0.
- yk_data = entry at the read pointer when yk_valid=1, else 0.
- Latency: a word pushed at edge N is visible on yk_valid/yk_data from just after edge N. It can be popped at edge N+1 at the earliest.
- Simultaneous push and pop on the same FIFO (only possible when not full): occupancy is unchanged and both pointers advance.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, ranging 0..DEPTH.
- Word order is preserved per output. There is no ordering guarantee across outputs.
- cntk increments by 1 on each pop of FIFO k and holds at 2^CNTW-1. Counters clear only on reset.
- No state machine beyond the FIFO occupancy.

Decomposition:
- Shared package: the parameter constraint check (DEPTH a power of two, at least 2) and a log2 helper for pointer widths.
- One sub-module, stream_fifo (WIDTH, DEPTH):
  - Inputs push/pop, outputs full/empty.
  - Read data is 0 when empty.
  - Instantiated twice, once per output.
- The top level holds the select steering, the in_ready mux and the two counters.

Test Plan:
1. Reset routing: after reset, push 0xA5 with in_sel=0. Expect y0_valid=1 and y0_data=0xA5 the cycle after acceptance, y1_valid=0. Pop it and expect cnt0=1, cnt1=0.
2. Backpressure isolation:
   - Hold y0_ready=0 and push 0x11, 0x22 to y0 (DEPTH=2). Expect in_ready=0 on the next sel=0 word.
   - Push 0x33 with sel=1. Expect it accepted and seen on y1 while y0 is still stalled.
3. Full plus pop in the same cycle: with y0 full and y0_ready=1 while pushing sel=0, expect in_ready=0 in that cycle. The push is accepted one cycle later and order out of y0 is 0x11, 0x22, 0x44.
4. Streaming and wrap: push 0x00..0x09 alternately to y0/y1 with both readies held at 1. Expect y0 to emit 0x00,0x02,...,0x08 and y1 to emit 0x01,...,0x09 with no loss after pointer wrap. cnt0=cnt1=5.
5. Saturation: with CNTW=3, pop 9 words from y1. Expect cnt1 to hold at 7.
6. Reset mid-operation: with y0 holding 2 words, pulse rst_n low between clock edges. Expect y0_valid=0, y0_data=0, cnt0=0 immediately and in_ready=1. No stale word appears after release.
